flag_union_fifo: RTL and testbench

- Parametrised buffered carrier for the packed flag-union word: OUTER x INNER lanes of 3 bits each.
- Each beat is read in one of two views:
  - A view: common flags a, b, c.
  - B view: pad bit plus 2-bit class enum a, b, c, d.
- Beats enter a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- A per-beat lane summary (count, any flag) is computed at accept time and travels with the beat.
- Sits between flag producers and consumers that previously used a plain combinational pass-through.

---
 rtl/flag_union_fifo.sv | 115 +++++++++++
 tb/tb_flag_union_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_union_fifo.sv
// Buffered carrier for the packed flag-union word: DEPTH-entry FIFO with
// valid/ready on both sides and a per-beat lane summary captured at accept.
module flag_union_fifo #(
    parameter  int unsigned OUTER = 4,
    parameter  int unsigned INNER = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned LANES = OUTER * INNER,
    localparam int unsigned CNT_W = $clog2(LANES + 1),
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_mode_i,
    input  logic [3*LANES-1:0] in_data_i,
    input  logic [1:0]         match_class_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               out_mode_o,
    output logic [3*LANES-1:0] out_data_o,
    output logic [CNT_W-1:0]   out_count_o,
    output logic               out_any_o,
    output logic [OCC_W-1:0]   occupancy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3*LANES-1:0] mem_data_q  [DEPTH];
    logic               mem_mode_q  [DEPTH];
    logic [CNT_W-1:0]   mem_count_q [DEPTH];
    logic               mem_any_q   [DEPTH];

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             push, pop;
    logic [CNT_W-1:0] sum_count;
    logic             sum_any;
    logic [2:0]       lane;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Lane summary: A view counts 'a' flags and ORs 'c'; B view counts
    // lanes matching the requested class and flags any class-d lane.
    always_comb begin
        sum_count = '0;
        sum_any   = 1'b0;
        lane      = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane = in_data_i[3*l +: 3];
            if (!in_mode_i) begin
                if (lane[2]) sum_count = sum_count + CNT_W'(1);
                sum_any = sum_any | lane[0];
            end else begin
                if (lane[1:0] == match_class_i) sum_count = sum_count + CNT_W'(1);
                if (lane[1:0] == 2'b11) sum_any = 1'b1;
            end
        end
    end

    assign in_ready_o  = (occ_q < OCC_W'(DEPTH)) && !clear_i;
    assign out_valid_o = (occ_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i && !clear_i;

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      occ_d = occ_q + OCC_W'(1);
            else if (pop && !push) occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately unreset; validity comes solely from occ_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wr_ptr_q]  <= in_data_i;
            mem_mode_q[wr_ptr_q]  <= in_mode_i;
            mem_count_q[wr_ptr_q] <= sum_count;
            mem_any_q[wr_ptr_q]   <= sum_any;
        end
    end

    assign out_mode_o  = out_valid_o ? mem_mode_q[rd_ptr_q]  : 1'b0;
    assign out_data_o  = out_valid_o ? mem_data_q[rd_ptr_q]  : '0;
    assign out_count_o = out_valid_o ? mem_count_q[rd_ptr_q] : '0;
    assign out_any_o   = out_valid_o ? mem_any_q[rd_ptr_q]   : 1'b0;
    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_flag_union_fifo.sv
// Randomized and directed bench for flag_union_fifo against a queue-based
// reference model that recomputes lane summaries from the flag-union rules.
module tb_flag_union_fifo;

    localparam int unsigned OUTER = 4;
    localparam int unsigned INNER = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LANES = OUTER * INNER;
    localparam int unsigned W     = 3 * LANES;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         clear_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic         in_mode_i = 1'b0;
    logic [W-1:0] in_data_i = '0;
    logic [1:0]   match_class_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic         out_mode_o;
    logic [W-1:0] out_data_o;
    logic [5:0]   out_count_o;
    logic         out_any_o;
    logic [1:0]   occupancy_o;

    flag_union_fifo #(.OUTER(OUTER), .INNER(INNER), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_mode_i(in_mode_i),
        .in_data_i(in_data_i), .match_class_i(match_class_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_mode_o(out_mode_o),
        .out_data_o(out_data_o), .out_count_o(out_count_o), .out_any_o(out_any_o),
        .occupancy_o(occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           mode;
        logic [W-1:0] data;
        int           cnt;
        bit           any;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t summarize(input bit mode, input logic [W-1:0] d, input logic [1:0] mc);
        ent_t e;
        logic [2:0] lane;
        e.mode = mode;
        e.data = d;
        e.cnt  = 0;
        e.any  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane = d[3*l +: 3];
            if (!mode) begin
                e.cnt += int'(lane[2]);
                e.any |= lane[0];
            end else begin
                if (lane[1:0] == mc) e.cnt++;
                if (lane[1:0] == 2'd3) e.any = 1'b1;
            end
        end
        return e;
    endfunction

    // Inputs are set by the caller; compare outputs, then advance one edge.
    task automatic step();
        bit exp_ready, do_push, do_pop;
        ent_t e;
        #1;
        exp_ready = (q.size() < DEPTH) && !clear_i;
        check("in_ready", in_ready_o, exp_ready);
        check("occupancy", occupancy_o, q.size());
        check("out_valid", out_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            check("out_mode", out_mode_o, q[0].mode);
            check("out_data", out_data_o, q[0].data);
            check("out_count", out_count_o, q[0].cnt);
            check("out_any", out_any_o, q[0].any);
        end else begin
            check("out_data_empty", {out_mode_o, out_any_o, out_count_o, out_data_o}, 0);
        end
        do_push = in_valid_i && exp_ready;
        do_pop  = (q.size() != 0) && out_ready_i && !clear_i;
        e = summarize(in_mode_i, in_data_i, match_class_i);
        @(posedge clk_i);
        if (clear_i) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        #1;
    endtask

    logic [W-1:0] word;

    initial begin
        // reset state
        #2;
        check("rst_occ", occupancy_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_fields", {out_mode_o, out_any_o, out_count_o, out_data_o}, 0);
        #10 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        step();

        // A view, all lanes 3'b100
        for (int l = 0; l < LANES; l++) word[3*l +: 3] = 3'b100;
        in_valid_i = 1; in_mode_i = 0; in_data_i = word; out_ready_i = 0;
        step();
        in_valid_i = 0;
        check("a_valid", out_valid_o, 1);
        check("a_count32", out_count_o, 32);
        check("a_any0", out_any_o, 0);
        check("a_occ1", occupancy_o, 1);
        out_ready_i = 1;
        step();

        // B view: lanes 0..4 class 2, lane 7 class 3, match 2
        word = '0;
        for (int l = 0; l < 5; l++) word[3*l +: 3] = 3'b010;
        word[21 +: 3] = 3'b011;
        in_valid_i = 1; in_mode_i = 1; in_data_i = word; match_class_i = 2'd2; out_ready_i = 0;
        step();
        in_valid_i = 0;
        check("b_count5", out_count_o, 5);
        check("b_any1", out_any_o, 1);
        check("b_data", out_data_o, word);
        out_ready_i = 1;
        step();

        // fill with consumer stalled, third beat held off
        out_ready_i = 0; in_valid_i = 1; in_mode_i = 0;
        for (int n = 0; n < 3; n++) begin
            in_data_i = W'(n + 100);
            step();
        end
        check("full_ready0", in_ready_o, 0);
        check("full_occ2", occupancy_o, 2);
        in_valid_i = 0; out_ready_i = 1;
        for (int n = 0; n < 3; n++) step();

        // streaming at occupancy 1
        in_valid_i = 1; out_ready_i = 1;
        for (int n = 0; n < 11; n++) begin
            in_data_i = W'(n + 200);
            step();
            check("stream_occ1", occupancy_o, 1);
        end
        in_valid_i = 0;
        step();

        // clear while full with valid asserted
        out_ready_i = 0; in_valid_i = 1;
        in_data_i = W'(300); step();
        in_data_i = W'(301); step();
        clear_i = 1; in_data_i = W'(302);
        step();
        clear_i = 0; in_valid_i = 0;
        check("clr_occ0", occupancy_o, 0);
        check("clr_valid0", out_valid_o, 0);
        step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid_i    = 1'($urandom_range(0, 1));
            out_ready_i   = 1'($urandom_range(0, 1));
            clear_i       = ($urandom_range(0, 19) == 0);
            in_mode_i     = 1'($urandom_range(0, 1));
            match_class_i = 2'($urandom_range(0, 3));
            in_data_i     = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) in_data_i = '1;
            step();
        end
        clear_i = 0; in_valid_i = 0;

        // async reset with two stored beats
        out_ready_i = 1; step(); step();
        out_ready_i = 0; in_valid_i = 1;
        in_data_i = W'(400); step();
        in_data_i = W'(401); step();
        in_valid_i = 0;
        check("pre_rst_occ2", occupancy_o, 2);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_occ", occupancy_o, 0);
        check("arst_valid", out_valid_o, 0);
        check("arst_fields", {out_mode_o, out_any_o, out_count_o, out_data_o}, 0);
        q.delete();
        #3 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_ready", in_ready_o, 1);
        check("post_rst_valid", out_valid_o, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
